// File: rtl/framebuffer_flip_arbiter.sv
// framebuffer_flip_arbiter: round-robin back-buffer write arbiter with clear and
// tear-free bank-flip sequencing for the double-buffered display framebuffer.
module framebuffer_flip_arbiter #(
  parameter int ROWS = 8,
  parameter int COLUMNS = 32,
  parameter int DATA_W = 24,
  parameter int ADDR_W = $clog2(ROWS*COLUMNS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_valid,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ready,
  input  logic              wr1_valid,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ready,
  input  logic              clear_req,
  input  logic              flip_req,
  input  logic              safe_flip,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              front_bank,
  output logic              busy,
  output logic              flip_done
);
  localparam int PIX = ROWS*COLUMNS;
  localparam logic [1:0] S_RUN = 2'd0, S_CLEAR = 2'd1, S_PEND = 2'd2, S_ACK = 2'd3;
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic clr_pend_q, clr_pend_d, flip_pend_q, flip_pend_d;
  logic last_grant_q, last_grant_d, front_q, front_d;
  logic mem_we_q, mem_we_d, flip_done_q, flip_done_d;
  logic [ADDR_W:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic run_idle, acc0, acc1, acc, clearing, clear_last, enter_clear, enter_pend, in_range;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  // rst gates the readies so nothing is accepted while reset is held
  assign run_idle = rst & (state_q == S_RUN) & ~clr_pend_q & ~flip_pend_q;
  assign wr0_ready = run_idle & wr0_valid & (~wr1_valid | last_grant_q);
  assign wr1_ready = run_idle & wr1_valid & (~wr0_valid | ~last_grant_q);
  assign acc0 = wr0_valid & wr0_ready;
  assign acc1 = wr1_valid & wr1_ready;
  assign acc = acc0 | acc1;
  assign wa = acc0 ? wr0_addr : wr1_addr;
  assign wd = acc0 ? wr0_data : wr1_data;
  assign in_range = {1'b0, wa} < (ADDR_W+1)'(PIX);
  assign clearing = state_q == S_CLEAR;
  assign clear_last = cnt_q == ADDR_W'(PIX-1);
  assign enter_clear = (state_q == S_RUN) & clr_pend_q;
  assign enter_pend = (state_d == S_PEND) & (state_q != S_PEND);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    front_d = front_q;
    case (state_q)
      S_RUN: begin
        if (clr_pend_q) begin
          state_d = S_CLEAR;
          cnt_d = '0;
        end else if (flip_pend_q) state_d = S_PEND;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (clear_last) state_d = (flip_pend_q | flip_req) ? S_PEND : S_RUN;
      end
      S_PEND: begin
        if (safe_flip) begin
          state_d = S_ACK;
          front_d = ~front_q;
        end
      end
      default: state_d = S_RUN;
    endcase
  end
  always_comb begin
    clr_pend_d = (clr_pend_q | clear_req) & ~enter_clear;
    flip_pend_d = (flip_pend_q | flip_req) & ~enter_pend;
    flip_done_d = (state_q == S_PEND) & safe_flip;
    last_grant_d = acc0 ? 1'b0 : acc1 ? 1'b1 : last_grant_q;
    mem_we_d = clearing | (acc & in_range);
    mem_waddr_d = clearing ? {~front_q, cnt_q} : acc ? {~front_q, wa} : mem_waddr_q;
    mem_wdata_d = clearing ? '0 : acc ? wd : mem_wdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q <= '0;
      clr_pend_q <= 1'b0;
      flip_pend_q <= 1'b0;
      last_grant_q <= 1'b1;
      front_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      flip_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clr_pend_q <= clr_pend_d;
      flip_pend_q <= flip_pend_d;
      last_grant_q <= last_grant_d;
      front_q <= front_d;
      mem_we_q <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      flip_done_q <= flip_done_d;
    end
  end
  assign mem_we = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign front_bank = front_q;
  assign flip_done = flip_done_q;
  assign busy = (state_q != S_RUN) | clr_pend_q | flip_pend_q;
endmodule

// File: tb/tb_framebuffer_flip_arbiter.sv
// tb_framebuffer_flip_arbiter: randomized and directed checks of the flip arbiter
// against a behavioural model of banks, grants and write latency.
module tb_framebuffer_flip_arbiter;
  localparam int PIX = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic wr0_valid, wr1_valid, wr0_ready, wr1_ready;
  logic [7:0] wr0_addr, wr1_addr;
  logic [23:0] wr0_data, wr1_data;
  logic clear_req, flip_req, safe_flip;
  logic mem_we, front_bank, busy, flip_done;
  logic [8:0] mem_waddr;
  logic [23:0] mem_wdata;
  int checks = 0, failures = 0;
  bit m_front, m_last;
  logic e_we;
  logic [8:0] e_addr;
  logic [23:0] e_data;
  always #5 clk = ~clk;
  framebuffer_flip_arbiter dut (
    .clk(clk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .clear_req(clear_req), .flip_req(flip_req), .safe_flip(safe_flip),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .front_bank(front_bank), .busy(busy), .flip_done(flip_done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy0"}, wr0_ready, 0);
    check({tag, "_rdy1"}, wr1_ready, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_waddr"}, mem_waddr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_front"}, front_bank, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, flip_done, 0);
  endtask
  task automatic check_write(input string tag);
    check({tag, "_we"}, mem_we, e_we);
    if (e_we) begin
      check({tag, "_waddr"}, mem_waddr, e_addr);
      check({tag, "_wdata"}, mem_wdata, e_data);
    end
  endtask
  // free-running writers; the model predicts the grant from the round-robin rule
  task automatic rand_phase(input int n, input bit sf_noise);
    bit r0, r1;
    for (int i = 0; i < n; i++) begin
      check_write("rnd");
      check("rnd_front", front_bank, m_front);
      check("rnd_done", flip_done, 0);
      check("rnd_busy", busy, 0);
      wr0_valid = 1'($urandom_range(0, 1));
      wr1_valid = 1'($urandom_range(0, 1));
      wr0_addr = 8'($urandom_range(0, PIX-1));
      wr1_addr = 8'($urandom_range(0, PIX-1));
      wr0_data = 24'($urandom);
      wr1_data = 24'($urandom);
      safe_flip = sf_noise && ($urandom_range(0, 3) == 0);
      #1;
      r0 = wr0_valid && (!wr1_valid || m_last);
      r1 = wr1_valid && (!wr0_valid || !m_last);
      check("rnd_rdy0", wr0_ready, r0);
      check("rnd_rdy1", wr1_ready, r1);
      e_we = r0 | r1;
      e_addr = {~m_front, r0 ? wr0_addr : wr1_addr};
      e_data = r0 ? wr0_data : wr1_data;
      if (r0) m_last = 1'b0;
      else if (r1) m_last = 1'b1;
      step();
    end
    wr0_valid = 0; wr1_valid = 0; safe_flip = 0;
    check_write("rnd_last");
    e_we = 0;
  endtask
  initial begin
    int k;
    wr0_valid = 0; wr1_valid = 0; wr0_addr = 0; wr1_addr = 0; wr0_data = 0; wr1_data = 0;
    clear_req = 0; flip_req = 0; safe_flip = 0;
    #3 rst = 0;
    wr0_valid = 1; wr1_valid = 1;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk) rst = 1;
    wr0_valid = 0; wr1_valid = 0;
    step();
    m_front = 0; m_last = 1; e_we = 0;
    // contest with both writers always valid: grants alternate starting at port 0
    wr0_addr = 8'd5; wr0_data = 24'hFF0000; wr1_addr = 8'd9; wr1_data = 24'h00FF00;
    for (int i = 0; i < 6; i++) begin
      wr0_valid = 1; wr1_valid = 1;
      #1;
      check("rr_rdy0", wr0_ready, (i % 2) == 0);
      check("rr_rdy1", wr1_ready, (i % 2) == 1);
      step();
      check("rr_we", mem_we, 1);
      check("rr_waddr", mem_waddr, (i % 2) == 0 ? 9'h105 : 9'h109);
      check("rr_wdata", mem_wdata, (i % 2) == 0 ? 24'hFF0000 : 24'h00FF00);
    end
    wr0_valid = 0; wr1_valid = 0;
    step();
    check("rr_idle_we", mem_we, 0);
    m_last = 1;
    rand_phase(150, 1'b1);
    // flip: write in the request cycle completes, then writers stall until the flip
    wr0_valid = 1; wr0_addr = 8'd3; wr0_data = 24'hABCDEF; flip_req = 1;
    #1 check("flip_req_rdy0", wr0_ready, 1);
    step();
    flip_req = 0;
    check("flip_req_we", mem_we, 1);
    check("flip_req_waddr", mem_waddr, 9'h103);
    for (int i = 0; i < 40; i++) begin
      #1;
      check("pend_rdy0", wr0_ready, 0);
      check("pend_busy", busy, 1);
      check("pend_front", front_bank, 0);
      check("pend_done", flip_done, 0);
      step();
      check("pend_we", mem_we, 0);
    end
    safe_flip = 1;
    #1 check("sf_rdy0", wr0_ready, 0);
    step();
    safe_flip = 0;
    check("flip_front", front_bank, 1);
    check("flip_done", flip_done, 1);
    check("flip_ack_rdy0", wr0_ready, 0);
    m_front = 1;
    step();
    check("flip_done_low", flip_done, 0);
    check("flip_back_rdy0", wr0_ready, 1);
    step();
    wr0_valid = 0;
    check("postflip_we", mem_we, 1);
    check("postflip_waddr", mem_waddr, 9'h003);
    check("postflip_wdata", mem_wdata, 24'hABCDEF);
    m_last = 0;
    step();
    check("postflip_idle", mem_we, 0);
    // abort a pending flip with reset: front returns to 0
    flip_req = 1;
    step();
    flip_req = 0;
    repeat (5) step();
    check("pend2_busy", busy, 1);
    wr0_valid = 1; wr1_valid = 1;
    rst = 0;
    #1 check_reset_outputs("rst_pend");
    @(negedge clk) rst = 1;
    wr0_valid = 0; wr1_valid = 0;
    step();
    m_front = 0; m_last = 1;
    // clear and flip together: clear first, safe_flip during clear is ignored
    clear_req = 1; flip_req = 1;
    step();
    clear_req = 0; flip_req = 0; wr1_valid = 1; wr1_addr = 8'd77;
    k = 0;
    while (!mem_we && k < 10) begin
      check("clr_wait_rdy1", wr1_ready, 0);
      step();
      k++;
    end
    check("clr_started", mem_we, 1);
    for (int i = 0; i < PIX; i++) begin
      check("clr_we", mem_we, 1);
      check("clr_waddr", mem_waddr, {1'b1, 8'(i)});
      check("clr_wdata", mem_wdata, 0);
      check("clr_rdy1", wr1_ready, 0);
      safe_flip = (i == 50);
      step();
      safe_flip = 0;
    end
    check("clr_end_we", mem_we, 0);
    for (int i = 0; i < 10; i++) begin
      check("clrpend_front", front_bank, 0);
      check("clrpend_busy", busy, 1);
      check("clrpend_rdy1", wr1_ready, 0);
      check("clrpend_done", flip_done, 0);
      step();
    end
    safe_flip = 1;
    step();
    safe_flip = 0;
    check("clrflip_front", front_bank, 1);
    check("clrflip_done", flip_done, 1);
    step();
    check("clrflip_done_low", flip_done, 0);
    check("clrflip_rdy1", wr1_ready, 1);
    wr1_valid = 0;
    m_front = 1;
    step();
    check("clrflip_idle", mem_we, 0);
    rand_phase(100, 1'b1);
    // reset in the middle of a clear sweep
    clear_req = 1;
    step();
    clear_req = 0;
    k = 0;
    while (!(mem_we && mem_waddr[7:0] == 8'd100) && k < 300) begin
      step();
      k++;
    end
    check("clr100_reached", mem_waddr[7:0], 8'd100);
    wr0_valid = 1; wr1_valid = 1; wr0_addr = 8'd12; wr1_addr = 8'd34;
    rst = 0;
    #1 check_reset_outputs("rst_clr");
    @(negedge clk) rst = 1;
    #1;
    check("rel_rdy0", wr0_ready, 1);
    check("rel_rdy1", wr1_ready, 0);
    step();
    wr0_valid = 0; wr1_valid = 0;
    check("rel_we", mem_we, 1);
    check("rel_waddr", mem_waddr, 9'h10C);
    check("rel_front", front_bank, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
